// File: rtl/weight_rom_sequencer.sv
// weight_rom_sequencer: streams a ROM kernel NUM_PASSES times into an ap_fifo through a 2-entry skid buffer
module weight_rom_sequencer #(
  parameter int MEM_SIZE = 288,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PASSES = 1,
  localparam int ADDR_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic [ADDR_W-1:0]     weight_V_address0,
  output logic                  weight_V_ce0,
  input  logic [DATA_WIDTH-1:0] weight_V_q0,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d, occ, occ_left, slot;
  logic infl_q, pop, issue, last_addr, last_pass;
  assign occ = cnt_q + {1'b0, infl_q};
  assign pop = (cnt_q != 2'd0) & output_V_full_n;
  assign occ_left = occ - {1'b0, pop};
  assign issue = (state_q == RUN) & (occ_left < 2'd2);
  assign last_addr = addr_q == ADDR_W'(MEM_SIZE - 1);
  assign last_pass = pass_q == PASS_W'(NUM_PASSES - 1);
  // the in-flight word lands in the first free slot after this cycle's pop
  assign slot = cnt_q - {1'b0, pop};
  assign cnt_d = slot + {1'b0, infl_q};
  assign head_d = (infl_q && slot == 2'd0) ? weight_V_q0 : (pop ? tail_q : head_q);
  assign tail_d = (infl_q && slot == 2'd1) ? weight_V_q0 : tail_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    pass_d = pass_q;
    if (issue) begin
      addr_d = last_addr ? '0 : addr_q + 1'b1;
      pass_d = !last_addr ? pass_q : (last_pass ? '0 : pass_q + 1'b1);
    end
    case (state_q)
      IDLE:    state_d = ap_start ? RUN : IDLE;
      RUN:     state_d = (issue && last_addr && last_pass) ? DRAIN : RUN;
      DRAIN:   state_d = (occ_left == 2'd0) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      pass_q <= '0;
      cnt_q <= '0;
      infl_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pass_q <= pass_d;
      cnt_q <= cnt_d;
      infl_q <= issue;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  assign ap_idle = state_q == IDLE;
  assign ap_done = state_q == DONE;
  assign weight_V_address0 = addr_q;
  assign weight_V_ce0 = issue;
  assign output_V_din = head_q;
  assign output_V_write = pop;
endmodule
